// File: rtl/xor_share_arbiter_if.sv
// rtl/xor_share_arbiter_if.sv - requester/response bundle for the shared XOR arbiter
interface xor_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;
    logic [15:0]           busy_cnt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy_cnt
    );
endinterface

// File: rtl/xor_share_arbiter.sv
// rtl/xor_share_arbiter.sv - round-robin sharing of one registered a^b datapath
module xor_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    xor_share_arbiter_if.slave    bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   grant_idx;
    logic             grant_hit;
    logic [IDW:0]     scan;
    logic             free;
    logic             accept;
    logic [NREQ-1:0]  ready_vec;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [15:0]      busy_q;

    // Walk the requesters starting at the pointer; the first valid one wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ))
                scan = scan - (IDW+1)'(NREQ);
            if (!grant_hit && bus.req_valid[scan[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant_idx = scan[IDW-1:0];
            end
        end
    end

    assign free   = (state == S_EMPTY) || bus.rsp_ready;
    assign accept = reset_n && free && grant_hit;

    always_comb begin
        ready_vec = '0;
        if (accept)
            ready_vec[grant_idx] = 1'b1;
    end

    assign op_a     = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign op_b     = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    assign ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (accept) state_next = S_FULL;
            S_FULL: begin
                if (accept)
                    state_next = S_FULL;
                else if (bus.rsp_ready)
                    state_next = S_EMPTY;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= S_EMPTY;
        else
            state <= state_next;
    end

    // Result payload only moves on accept, so it stays put while draining to EMPTY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr        <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            busy_q     <= '0;
        end else if (accept) begin
            ptr        <= ptr_next;
            rsp_id_q   <= grant_idx;
            rsp_data_q <= op_a ^ op_b;
            if (busy_q != 16'hFFFF)
                busy_q <= busy_q + 16'd1;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = (state == S_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy_cnt  = busy_q;
endmodule
